// File: rtl/servo_motion_sequencer.sv
// Three-joint servo pose sequencer: slews base, shoulder, elbow one at a time toward a latched target.
// Optional target clamping to [MIN_PULSE, MAX_PULSE] with limit_hit pulse when SERVO_SOFT_LIMIT_EN is defined.
module servo_motion_sequencer #(
  parameter int WIDTH        = 24,
  parameter int TICK_CYCLES  = 200000,
  parameter int STEP         = 100,
  parameter int HOME         = 150000,
  parameter int MIN_PULSE    = 100000,
  parameter int MAX_PULSE    = 200000,
  parameter int SETTLE_TICKS = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_base,
  input  logic [WIDTH-1:0] cmd_shoulder,
  input  logic [WIDTH-1:0] cmd_elbow,
  output logic [WIDTH-1:0] base_angle,
  output logic [WIDTH-1:0] shoulder_angle,
  output logic [WIDTH-1:0] elbow_angle,
  output logic             pwm_en,
  output logic             busy,
  output logic [2:0]       state,
  output logic             limit_hit
);

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] MOVE_BASE     = 3'd1;
  localparam logic [2:0] MOVE_SHOULDER = 3'd2;
  localparam logic [2:0] MOVE_ELBOW    = 3'd3;
  localparam logic [2:0] SETTLE        = 3'd4;

  localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SCW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [TCW-1:0]   TICK_LAST   = TCW'(TICK_CYCLES - 1);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_TICKS);
  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] HOME_W      = WIDTH'(HOME);

  logic [TCW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                    tick;
  logic [2:0]              state_q, state_d;
  logic [SCW-1:0]          settle_q, settle_d;
  logic                    pwm_en_q, pwm_en_d;
  logic [2:0][WIDTH-1:0]   cur_q, cur_d;
  logic [2:0][WIDTH-1:0]   tgt_q, tgt_d;
  logic [2:0][WIDTH-1:0]   in_tgt;
  logic [1:0]              joint;

  // Move toward tgt by at most STEP; the bounded difference keeps unsigned math from wrapping.
  function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] tgt);
    if (tgt > cur) return ((tgt - cur) > STEP_W) ? cur + STEP_W : tgt;
    else           return ((cur - tgt) > STEP_W) ? cur - STEP_W : tgt;
  endfunction

`ifdef SERVO_SOFT_LIMIT_EN
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_PULSE);
  logic limit_q, limit_d;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < MIN_W)      return MIN_W;
    else if (v > MAX_W) return MAX_W;
    else                return v;
  endfunction

  always_comb begin
    in_tgt  = {clamp(cmd_elbow), clamp(cmd_shoulder), clamp(cmd_base)};
    limit_d = (state_q == IDLE) && cmd_valid &&
              (in_tgt != {cmd_elbow, cmd_shoulder, cmd_base});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) limit_q <= 1'b0;
    else       limit_q <= limit_d;
  end

  assign limit_hit = limit_q;
`else
  always_comb in_tgt = {cmd_elbow, cmd_shoulder, cmd_base};
  assign limit_hit = 1'b0;
`endif

  assign tick  = (tick_cnt_q == TICK_LAST);
  assign joint = state_q[1:0] - 2'd1;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    state_d    = state_q;
    settle_d   = '0;
    pwm_en_d   = pwm_en_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d    = in_tgt;
          pwm_en_d = 1'b1;
          state_d  = MOVE_BASE;
        end
      end
      MOVE_BASE, MOVE_SHOULDER, MOVE_ELBOW: begin
        if (cur_q[joint] == tgt_q[joint]) state_d = state_q + 3'd1;
        else if (tick)                    cur_d[joint] = slew(cur_q[joint], tgt_q[joint]);
      end
      SETTLE: begin
        settle_d = settle_q;
        if (settle_q == SETTLE_LAST) state_d  = IDLE;
        else if (tick)               settle_d = settle_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      settle_q   <= '0;
      pwm_en_q   <= 1'b0;
      cur_q      <= {3{HOME_W}};
      tgt_q      <= {3{HOME_W}};
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      settle_q   <= settle_d;
      pwm_en_q   <= pwm_en_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign state          = state_q;
  assign pwm_en         = pwm_en_q;
  assign base_angle     = cur_q[0];
  assign shoulder_angle = cur_q[1];
  assign elbow_angle    = cur_q[2];

endmodule
